// File: rtl/systolic_pkg.sv
// Shared defaults and FSM state type for the systolic array feeder.
package systolic_pkg;

   localparam int unsigned ROWS_DEF = 4;
   localparam int unsigned DW_DEF   = 8;
   localparam int unsigned LW_DEF   = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_W = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_e;

endpackage

// File: rtl/systolic_feeder_if.sv
// Job control, weight/feature handshakes and array-edge outputs of the feeder.
interface systolic_feeder_if
   import systolic_pkg::*;
#(
   parameter int unsigned ROWS = ROWS_DEF,
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned LW   = LW_DEF
);

   logic                 start;
   logic [LW-1:0]        len;
   logic [ROWS*DW-1:0]   w_data;
   logic                 w_valid;
   logic                 w_ready;
   logic [ROWS*DW-1:0]   f_data;
   logic                 f_valid;
   logic                 f_ready;
   logic [ROWS*DW-1:0]   fm_out;
   logic [ROWS*DW-1:0]   wm_out;
   logic                 wen;
   logic                 busy;
   logic                 done;

   // Job/data source side
   modport master (
      output start, len, w_data, w_valid, f_data, f_valid,
      input  w_ready, f_ready, fm_out, wm_out, wen, busy, done
   );

   // Feeder side
   modport slave (
      input  start, len, w_data, w_valid, f_data, f_valid,
      output w_ready, f_ready, fm_out, wm_out, wen, busy, done
   );

endinterface

// File: rtl/skew_line.sv
// Fixed-depth register chain delaying one FM lane by DEPTH cycles.
module skew_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] d_i,
   output logic [DW-1:0] q_o
);

   logic [DW-1:0] pipe_q [DEPTH];

   // Shift the lane value one stage per cycle; reset empties the chain
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Loads ROWS weight rows into the array, then streams skewed feature vectors and drains.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int unsigned ROWS = ROWS_DEF,
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned LW   = LW_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   systolic_feeder_if.slave     bus
);

   localparam int unsigned VW  = ROWS * DW;
   localparam int unsigned RW  = $clog2(ROWS);
   localparam int unsigned DCW = $clog2(2 * ROWS);

   state_e          state_q, state_d;
   logic [RW-1:0]   row_cnt_q, row_cnt_d;
   logic [LW-1:0]   vec_cnt_q, vec_cnt_d;
   logic [LW-1:0]   len_q, len_d;
   logic [DCW-1:0]  drn_cnt_q, drn_cnt_d;
   logic [VW-1:0]   wm_q, wm_d;
   logic            wen_q, wen_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            w_ready_q, w_ready_d;
   logic            f_ready_q, f_ready_d;

   logic            w_hs_c;
   logic            f_hs_c;
   logic            last_row_c;
   logic            last_vec_c;
   logic            last_drn_c;
   logic [VW-1:0]   skew_in_c;
   logic [VW-1:0]   skew_q;

   assign w_hs_c     = bus.w_valid & w_ready_q;
   assign f_hs_c     = bus.f_valid & f_ready_q;
   assign last_row_c = (row_cnt_q == RW'(ROWS - 1));
   assign last_vec_c = (vec_cnt_q == (len_q - LW'(1)));
   assign last_drn_c = (drn_cnt_q == DCW'(2 * ROWS - 2));

   // Idle STREAM cycles and all other states push zeros into the skew lines
   assign skew_in_c  = f_hs_c ? bus.f_data : '0;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (bus.start) state_d = S_LOAD_W;
         S_LOAD_W: if (w_hs_c && last_row_c) state_d = (len_q != '0) ? S_STREAM : S_DRAIN;
         S_STREAM: if (f_hs_c && last_vec_c) state_d = S_DRAIN;
         S_DRAIN:  if (last_drn_c) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Counters, weight capture and registered status for the next cycle
   always_comb begin
      row_cnt_d = row_cnt_q;
      vec_cnt_d = vec_cnt_q;
      len_d     = len_q;
      drn_cnt_d = drn_cnt_q;
      wm_d      = wm_q;
      wen_d     = 1'b0;
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
      w_ready_d = (state_d == S_LOAD_W);
      f_ready_d = (state_d == S_STREAM);

      if (state_q == S_IDLE && bus.start) begin
         len_d     = bus.len;
         row_cnt_d = '0;
         vec_cnt_d = '0;
         drn_cnt_d = '0;
      end
      if (w_hs_c) begin
         wm_d  = bus.w_data;
         wen_d = 1'b1;
         if (row_cnt_q != '1) row_cnt_d = row_cnt_q + RW'(1);
      end
      if (f_hs_c && vec_cnt_q != '1) vec_cnt_d = vec_cnt_q + LW'(1);
      if (state_q == S_DRAIN && drn_cnt_q != '1) drn_cnt_d = drn_cnt_q + DCW'(1);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt_q <= '0;
         vec_cnt_q <= '0;
         len_q     <= '0;
         drn_cnt_q <= '0;
         wm_q      <= '0;
         wen_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         w_ready_q <= 1'b0;
         f_ready_q <= 1'b0;
      end else begin
         row_cnt_q <= row_cnt_d;
         vec_cnt_q <= vec_cnt_d;
         len_q     <= len_d;
         drn_cnt_q <= drn_cnt_d;
         wm_q      <= wm_d;
         wen_q     <= wen_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         w_ready_q <= w_ready_d;
         f_ready_q <= f_ready_d;
      end
   end

   // Lane r is delayed r+1 cycles so the wavefront enters the array diagonally
   for (genvar r = 0; r < int'(ROWS); r++) begin : g_lane
      skew_line #(
         .DEPTH (r + 1),
         .DW    (DW)
      ) u_skew (
         .clk (clk),
         .rst (rst),
         .d_i (skew_in_c[r*DW +: DW]),
         .q_o (skew_q[r*DW +: DW])
      );
   end

   assign bus.fm_out  = skew_q;
   assign bus.wm_out  = wm_q;
   assign bus.wen     = wen_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.w_ready = w_ready_q;
   assign bus.f_ready = f_ready_q;

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter ROWS, default 4: array rows/columns, range 2..16.
REQ-002 SHALL have parameter DW, default 8: operand width, equal to MAC FM/WM width.
REQ-003 SHALL have parameter LW, default 8: frame-length counter width.
REQ-004 Port clk  input  1  sole clock; all logic on the rising edge.
REQ-005 Port rst  input  1  reset; synchronous and active-high.
REQ-006 Port start  input  1  one-cycle request to begin a load+stream job.
REQ-007 Port len  input  LW  number of feature vectors in the job; sampled when start is accepted.
REQ-008 Port w_data  input  ROWS*DW  one weight row, lane c in bits [c*DW +: DW].
REQ-009 Port w_valid / w_ready  input / output  1 each  weight-row handshake.
REQ-010 Port f_data  input  ROWS*DW  one feature vector, lane r in bits [r*DW +: DW].
REQ-011 Port f_valid / f_ready  input / output  1 each  feature-vector handshake.
REQ-012 Port fm_out  output  ROWS*DW  skewed FM lanes to the west edge of the array.
REQ-013 Port wm_out  output  ROWS*DW  WM lanes to the north edge of the array.
REQ-014 Port wen  output  1  weight-enable to the array, shared by all columns.
REQ-015 Port busy / done  output  1 each  job in progress / one-cycle completion pulse.

Function
REQ-016 States: IDLE, LOAD_W, STREAM, DRAIN, DONE; transitions only on clk.
REQ-017 IDLE: start=1 -> LOAD_W, latch len, clear counters; busy=1 from the next cycle until return to IDLE.
REQ-018 A start asserted outside IDLE SHALL be ignored.
REQ-019 LOAD_W: w_ready=1; each w_valid&w_ready handshake registers w_data into wm_out and sets wen=1 on the following cycle; otherwise wen=0 and wm_out holds.
REQ-020 LOAD_W SHALL accept exactly ROWS weight rows. The first row accepted lands in array row ROWS-1 and the last in row 0. After the ROWS-th handshake, go to STREAM (len>0) or DRAIN (len=0).
REQ-021 STREAM: f_ready=1; a vector accepted in cycle t drives lane r onto fm_out lane r in cycle t+1+r.
REQ-022 In a STREAM cycle without a handshake, a zero vector SHALL enter the skew lines; the vector count SHALL NOT advance.
REQ-023 After len accepted vectors, go to DRAIN.
REQ-024 DRAIN: inject zero vectors for exactly 2*ROWS-1 cycles to flush the skew lines and array, then go to DONE.
REQ-025 DONE: done=1 for one cycle, then go to IDLE with busy=0.
REQ-026 w_ready=0 outside LOAD_W; f_ready=0 outside STREAM; wen=0 outside the cycle after a weight handshake.
REQ-027 Vector and row counters SHALL saturate and never wrap; len=2^LW-1 is legal.

Reset
REQ-028 rst=1 at any clock edge, including mid-job, SHALL force state IDLE and clear counters and all skew registers.
REQ-029 During and after reset: fm_out=0, wm_out=0, wen=0, busy=0, done=0, w_ready=0, f_ready=0.

Structure
REQ-030 Package systolic_pkg SHALL hold the ROWS and DW defaults and the state enum type.
REQ-031 A sub-module skew_line (parameter DEPTH, DW-wide register chain with sync reset) SHALL be instantiated once per lane, with DEPTH=r+1 for lane r.

Verification
REQ-032 ROWS=4, start, len=1, weight rows 0x01..0x04 with no gaps -> wen=1 for 4 consecutive cycles, wm_out shows 01,02,03,04 per lane.
REQ-033 Vector {4,3,2,1} accepted at cycle t -> fm_out lanes 0..3 show 1,2,3,4 at t+1, t+2, t+3, t+4 respectively; zeros elsewhere.
REQ-034 w_valid toggled 1,0,1,0 -> wen follows one cycle late, wm_out holds through gaps, still exactly 4 handshakes.
REQ-035 len=0 -> LOAD_W, then DRAIN for 7 cycles, then done for one cycle; f_ready never 1.
REQ-036 rst raised during STREAM after 2 of 5 vectors -> next cycle all outputs 0 and state IDLE; a new start runs a full job correctly.
REQ-037 start pulsed during STREAM -> ignored; exactly one done per job.
